// File: rtl/rasterint_gen.sv
// rasterint_gen: Z80 /INT generator for raster-line and vertical-retrace
// interrupts. Compares the ULA counters against the programmed raster line
// and a fixed retrace position, then emits a fixed-width active-low pulse.
// Handshake-free: every decision is qualified by the ce clock enable, and a
// trigger is acted on at the clk edge that samples it (no extra pipeline).
// Optional macro RASTERINT_PENDING_EN: a trigger seen while a pulse is
// active is remembered and replayed after a one-ce-cycle high gap.
module rasterint_gen #(
    parameter int         INT_LEN       = 32,
    parameter logic [8:0] RASTER_HC     = 9'd256,
    parameter logic [8:0] VRETRACE_LINE = 9'd248,
    parameter logic [8:0] VRETRACE_HC   = 9'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [8:0] hc,
    input  logic [8:0] vc,
    input  logic [8:0] raster_line,
    input  logic       rasterint_enable,
    input  logic       vretraceint_disable,
    output logic       int_n,
    output logic       raster_int_in_progress,
    output logic       pulse_active
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_VRET   = 2'd1;
    localparam logic [1:0] ST_RASTER = 2'd2;

    // Counter is loaded with INT_LEN-1 so the terminating cycle is the
    // INT_LEN-th ce cycle of the pulse.
    localparam logic [5:0] CNT_LOAD = 6'(INT_LEN - 1);

    logic [1:0] state;
    logic [5:0] count;
    logic       raster_hit;
    logic       vret_hit;
    logic       start_raster;
    logic       start_vret;

    assign raster_hit = rasterint_enable && (vc == raster_line) && (hc == RASTER_HC);
    assign vret_hit   = !vretraceint_disable && (vc == VRETRACE_LINE) && (hc == VRETRACE_HC);

`ifdef RASTERINT_PENDING_EN
    logic pend;
    logic pend_raster;

    // Remember triggers that arrive mid-pulse; cleared on any ce cycle in
    // IDLE, which is exactly when a pending request is consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= 1'b0;
            pend_raster <= 1'b0;
        end else if (ce) begin
            if (state != ST_IDLE) begin
                if (raster_hit || vret_hit) begin
                    pend        <= 1'b1;
                    pend_raster <= raster_hit || (pend && pend_raster);
                end
            end else begin
                pend        <= 1'b0;
                pend_raster <= 1'b0;
            end
        end
    end

    // A raster request (pending or live) always wins over retrace.
    assign start_raster = raster_hit || (pend && pend_raster);
    assign start_vret   = vret_hit || pend;
`else
    assign start_raster = raster_hit;
    assign start_vret   = vret_hit;
`endif

    // Pulse FSM: IDLE waits for a trigger, INT states count the pulse down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= ST_IDLE;
            count                  <= 6'd0;
            int_n                  <= 1'b1;
            raster_int_in_progress <= 1'b0;
        end else if (ce) begin
            case (state)
                ST_IDLE: begin
                    if (start_raster) begin
                        state                  <= ST_RASTER;
                        count                  <= CNT_LOAD;
                        int_n                  <= 1'b0;
                        raster_int_in_progress <= 1'b1;
                    end else if (start_vret) begin
                        state <= ST_VRET;
                        count <= CNT_LOAD;
                        int_n <= 1'b0;
                    end
                end
                default: begin
                    if (count != 6'd0) begin
                        count <= count - 6'd1;
                    end else begin
                        state                  <= ST_IDLE;
                        int_n                  <= 1'b1;
                        raster_int_in_progress <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign pulse_active = ~int_n;

endmodule

// File: tb/tb_rasterint_gen.sv
// tb_rasterint_gen: directed scenarios followed by random traffic. Each
// driven cycle runs a behavioural model of the interrupt rules and queues
// the expected {int_n, raster_int_in_progress, pulse_active}; a monitor pops
// and compares one entry after every clk edge.
module tb_rasterint_gen;

    localparam int         INT_LEN = 32;
    localparam logic [8:0] R_HC    = 9'd256;
    localparam logic [8:0] V_LINE  = 9'd248;
    localparam logic [8:0] V_HC    = 9'd256;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b0;
    logic [8:0] hc = 9'd0;
    logic [8:0] vc = 9'd0;
    logic [8:0] raster_line = 9'h1FF;
    logic       rasterint_enable = 1'b0;
    logic       vretraceint_disable = 1'b1;
    logic       int_n;
    logic       raster_int_in_progress;
    logic       pulse_active;

    // Configuration staged by scenarios, applied to the DUT at the next drive.
    logic [8:0] t_line = 9'h1FF;
    logic       t_en = 1'b0;
    logic       t_dis = 1'b1;

    logic [2:0] exp_q[$];
    int         tests = 0;
    int         failed = 0;

    // Reference model state: remaining low ce cycles and pulse kind.
    int         m_left = 0;
    logic       m_raster = 1'b0;
    logic       m_pend = 1'b0;
    logic       m_pend_raster = 1'b0;

    rasterint_gen #(
        .INT_LEN(INT_LEN),
        .RASTER_HC(R_HC),
        .VRETRACE_LINE(V_LINE),
        .VRETRACE_HC(V_HC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ce(ce),
        .hc(hc),
        .vc(vc),
        .raster_line(raster_line),
        .rasterint_enable(rasterint_enable),
        .vretraceint_disable(vretraceint_disable),
        .int_n(int_n),
        .raster_int_in_progress(raster_int_in_progress),
        .pulse_active(pulse_active)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural rules applied to whatever is on the DUT inputs this cycle.
    task automatic model_step();
        logic r_hit;
        logic v_hit;
        r_hit = rasterint_enable && (vc == raster_line) && (hc == R_HC);
        v_hit = !vretraceint_disable && (vc == V_LINE) && (hc == V_HC);
        if (rst) begin
            m_left = 0;
            m_raster = 1'b0;
            m_pend = 1'b0;
            m_pend_raster = 1'b0;
        end else if (ce) begin
            if (m_left > 0) begin
`ifdef RASTERINT_PENDING_EN
                if (r_hit || v_hit) begin
                    m_pend_raster = r_hit || (m_pend && m_pend_raster);
                    m_pend = 1'b1;
                end
`endif
                m_left = m_left - 1;
            end else begin
                if (r_hit || (m_pend && m_pend_raster)) begin
                    m_left = INT_LEN;
                    m_raster = 1'b1;
                end else if (v_hit || m_pend) begin
                    m_left = INT_LEN;
                    m_raster = 1'b0;
                end
                m_pend = 1'b0;
                m_pend_raster = 1'b0;
            end
        end
    endtask

    // Driver: apply one cycle of inputs at the falling edge, queue expectation.
    task automatic drive(input logic c, input logic [8:0] h, input logic [8:0] v, input logic r);
        @(negedge clk);
        ce = c;
        hc = h;
        vc = v;
        rst = r;
        raster_line = t_line;
        rasterint_enable = t_en;
        vretraceint_disable = t_dis;
        model_step();
        exp_q.push_back({(m_left == 0), (m_left > 0) && m_raster, (m_left > 0)});
    endtask

    // Idle cycles at a counter position that matches nothing.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 9'd300, 9'd5, 1'b0);
    endtask

    // Sweep hc across the trigger column on one line.
    task automatic sweep(input logic [8:0] v);
        for (int i = 250; i < 262; i++) drive(1'b1, 9'(i), v, 1'b0);
    endtask

    // Scoreboard monitor
    initial begin
        logic [2:0] exp;
        logic [2:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                exp = exp_q.pop_front();
                got = {int_n, raster_int_in_progress, pulse_active};
                tests++;
                if (got !== exp) begin
                    failed++;
                    $display("FAIL int_outputs t=%0t got {int_n,rip,pa}=%b expected %b", $time, got, exp);
                end
            end
        end
    end

    // Stimulus
    initial begin
        logic [8:0] h;
        logic [8:0] v;
        int         k;

        // Reset
        for (int i = 0; i < 3; i++) drive(1'b1, 9'd0, 9'd0, 1'b1);

        // Raster basic on line 100
        t_line = 9'd100; t_en = 1'b1; t_dis = 1'b1;
        sweep(9'd100);
        idle(40);

        // Vertical retrace enabled, then suppressed
        t_en = 1'b0; t_dis = 1'b0;
        sweep(V_LINE);
        idle(40);
        t_dis = 1'b1;
        sweep(V_LINE);
        idle(10);

        // Collision: both sources at the same position
        t_line = V_LINE; t_en = 1'b1; t_dis = 1'b0;
        sweep(V_LINE);
        idle(40);

        // Unreachable raster line over a whole frame
        t_line = 9'h1FF; t_en = 1'b1; t_dis = 1'b1;
        for (int i = 0; i < 312; i++) drive(1'b1, R_HC, 9'(i), 1'b0);

        // ce every 4th clock, full pulse
        t_line = 9'd60; t_en = 1'b1;
        drive(1'b1, R_HC, 9'd60, 1'b0);
        for (int i = 1; i <= 140; i++) drive((i % 4) == 0, 9'd300, 9'd5, 1'b0);
        // ce every 4th clock, reset at clock 50 of the pulse
        drive(1'b1, R_HC, 9'd60, 1'b0);
        for (int i = 1; i <= 60; i++) drive((i % 4) == 0, 9'd300, 9'd5, i == 50);
        idle(5);

        // Back-to-back: raster hit at cycle 10 of a retrace pulse
        t_line = 9'd20; t_en = 1'b1; t_dis = 1'b0;
        drive(1'b1, V_HC, V_LINE, 1'b0);
        idle(9);
        drive(1'b1, R_HC, 9'd20, 1'b0);
        idle(80);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                t_line = 9'($urandom_range(0, 311));
                t_en = 1'($urandom_range(0, 1));
                t_dis = 1'($urandom_range(0, 1));
            end
            k = $urandom_range(0, 3);
            h = (k == 0) ? R_HC : (k == 1) ? V_HC : 9'($urandom_range(0, 447));
            k = $urandom_range(0, 3);
            v = (k == 0) ? t_line : (k == 1) ? V_LINE : 9'($urandom_range(0, 311));
            drive($urandom_range(0, 3) != 0, h, v, $urandom_range(0, 299) == 0);
        end
        idle(2);

        // Drain with a bound
        k = 0;
        while (exp_q.size() != 0 && k < 10) begin
            @(posedge clk);
            k++;
        end
        #2;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL drain_timeout left=%0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
